pcie_phy_rx_deframer: RTL and testbench

Receive-side counterpart of the PHY transmit mux. Takes the serialised byte/control-flag symbol stream the transmitter produces and separates it back into framed packets and ordered sets:
- TLP packets, framed STP ... END.
- DLLP packets, framed SDP ... END.
- SKP ordered sets, COM followed by SKPs.
- Logical idle.

It sits between the lane symbol stream and the data-link layer. It flags framing violations on ERROR_DLL.

---
 rtl/pcie_phy_rx_deframer_pkg.sv | 32 +++
 rtl/pcie_phy_rx_deframer_classify.sv | 32 +++
 rtl/pcie_phy_rx_deframer.sv | 184 ++++++++++++++++++
 tb/tb_pcie_phy_rx_deframer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_rx_deframer_pkg.sv
// Symbol constants, FSM state encodings and symbol-class indices for the PCIe PHY.
// The transmit side imports the same package so both directions agree on symbols.
package pcie_phy_rx_deframer_pkg;

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_EDB = 8'hFE;
    localparam logic [7:0] SYM_IDL = 8'h00;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TLP  = 2'd1;
    localparam logic [1:0] ST_DLLP = 2'd2;
    localparam logic [1:0] ST_OS   = 2'd3;

    // Bit positions inside the one-hot symbol class vector
    localparam int CLS_DATA = 0;
    localparam int CLS_IDLE = 1;
    localparam int CLS_COM  = 2;
    localparam int CLS_SKP  = 3;
    localparam int CLS_STP  = 4;
    localparam int CLS_SDP  = 5;
    localparam int CLS_END  = 6;
    localparam int CLS_EDB  = 7;
    localparam int CLS_ILLK = 8;
    localparam int CLS_W    = 9;

    typedef logic [CLS_W-1:0] sym_class_t;

endpackage

// File: rtl/pcie_phy_rx_deframer_classify.sv
// Maps one received {K flag, byte} symbol onto a one-hot class vector.
// A data 8'h00 is logical idle; any K code not listed is illegal.
module pcie_phy_symbol_classify
    import pcie_phy_rx_deframer_pkg::*;
(
    input  logic       rx_k_i,
    input  logic [7:0] rx_data_i,
    output sym_class_t class_o
);

    always_comb begin
        class_o = '0;
        if (!rx_k_i) begin
            if (rx_data_i == SYM_IDL) begin
                class_o[CLS_IDLE] = 1'b1;
            end else begin
                class_o[CLS_DATA] = 1'b1;
            end
        end else begin
            case (rx_data_i)
                SYM_COM: class_o[CLS_COM]  = 1'b1;
                SYM_SKP: class_o[CLS_SKP]  = 1'b1;
                SYM_STP: class_o[CLS_STP]  = 1'b1;
                SYM_SDP: class_o[CLS_SDP]  = 1'b1;
                SYM_END: class_o[CLS_END]  = 1'b1;
                SYM_EDB: class_o[CLS_EDB]  = 1'b1;
                default: class_o[CLS_ILLK] = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pcie_phy_rx_deframer.sv
// Receive deframer: splits the lane symbol stream into TLP/DLLP payload and SKP
// ordered sets, with one cycle of registered latency and framing-error pulses.
module pcie_phy_rx_deframer
    import pcie_phy_rx_deframer_pkg::*;
#(
    parameter int MAX_LEN  = 32,
    parameter int DLLP_LEN = 6,
    parameter int MAX_SKP  = 5
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic [7:0] RX_DATA,
    input  logic       RX_K,
    input  logic       RX_VALID,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID,
    output logic       PKT_START,
    output logic       PKT_END,
    output logic       PKT_TYPE,
    output logic       SKP_OS,
    output logic       ERROR_DLL
);

    localparam int CNT_W = $clog2(MAX_LEN + 2);
    localparam int SKP_W = $clog2(MAX_SKP + 2);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_DLLP = CNT_W'(DLLP_LEN);
    localparam logic [SKP_W-1:0] SKP_ONE  = SKP_W'(1);
    localparam logic [SKP_W-1:0] SKP_LIM  = SKP_W'(MAX_SKP);

    sym_class_t cls;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] byteCnt_q, byteCnt_d;
    logic [SKP_W-1:0] skpCnt_q, skpCnt_d;
    logic [7:0]       dataOut_q, dataOut_d;
    logic             dataValid_q, dataValid_d;
    logic             pktStart_q, pktStart_d;
    logic             pktEnd_q, pktEnd_d;
    logic             pktType_q, pktType_d;
    logic             skpOs_q, skpOs_d;
    logic             errDll_q, errDll_d;
    logic             decodeIdle;
    logic             dropping;

    pcie_phy_symbol_classify u_classify (
        .rx_k_i   (RX_K),
        .rx_data_i(RX_DATA),
        .class_o  (cls)
    );

    // An overflowed TLP parks its counter at MAX_LEN+1; the packet has already
    // been closed, so the tail is swallowed silently until END/EDB.
    assign dropping = (state_q == ST_TLP) && (byteCnt_q == CNT_OVF);

    always_comb begin
        state_d     = state_q;
        byteCnt_d   = byteCnt_q;
        skpCnt_d    = skpCnt_q;
        dataOut_d   = dataOut_q;
        pktType_d   = pktType_q;
        dataValid_d = 1'b0;
        pktStart_d  = 1'b0;
        pktEnd_d    = 1'b0;
        skpOs_d     = 1'b0;
        errDll_d    = 1'b0;
        decodeIdle  = 1'b0;

        if (RX_VALID) begin
            case (state_q)
                ST_TLP, ST_DLLP: begin
                    if (cls[CLS_DATA] || cls[CLS_IDLE]) begin
                        if (state_q == ST_TLP && byteCnt_q == CNT_MAX) begin
                            errDll_d  = 1'b1;
                            pktEnd_d  = 1'b1;
                            byteCnt_d = CNT_OVF;
                        end else if (!dropping) begin
                            dataOut_d   = RX_DATA;
                            dataValid_d = 1'b1;
                            pktStart_d  = (byteCnt_q == '0);
                            if (byteCnt_q != CNT_OVF) begin
                                byteCnt_d = byteCnt_q + CNT_ONE;
                            end
                        end
                    end else if (cls[CLS_END]) begin
                        state_d = ST_IDLE;
                        if (!dropping) begin
                            pktEnd_d = 1'b1;
                            errDll_d = (byteCnt_q == '0) ||
                                       (state_q == ST_DLLP && byteCnt_q != CNT_DLLP);
                        end
                    end else if (cls[CLS_EDB]) begin
                        state_d = ST_IDLE;
                        if (!dropping) begin
                            pktEnd_d = 1'b1;
                            errDll_d = 1'b1;
                        end
                    end else begin
                        errDll_d   = 1'b1;
                        pktEnd_d   = !dropping;
                        decodeIdle = 1'b1;
                    end
                end
                ST_OS: begin
                    if (cls[CLS_SKP]) begin
                        if (skpCnt_q == SKP_LIM) begin
                            errDll_d = 1'b1;
                            state_d  = ST_IDLE;
                            skpCnt_d = '0;
                        end else begin
                            skpCnt_d = skpCnt_q + SKP_ONE;
                        end
                    end else begin
                        if (skpCnt_q != '0) begin
                            skpOs_d = 1'b1;
                        end else begin
                            errDll_d = 1'b1;
                        end
                        decodeIdle = 1'b1;
                    end
                end
                default: decodeIdle = 1'b1;
            endcase

            // Shared IDLE decode, also reached when a frame ends on a foreign symbol
            if (decodeIdle) begin
                state_d = ST_IDLE;
                if (cls[CLS_STP]) begin
                    state_d   = ST_TLP;
                    byteCnt_d = '0;
                    pktType_d = 1'b0;
                end else if (cls[CLS_SDP]) begin
                    state_d   = ST_DLLP;
                    byteCnt_d = '0;
                    pktType_d = 1'b1;
                end else if (cls[CLS_COM]) begin
                    state_d  = ST_OS;
                    skpCnt_d = '0;
                end else if (cls[CLS_DATA] || cls[CLS_ILLK] || cls[CLS_SKP] ||
                             cls[CLS_END] || cls[CLS_EDB]) begin
                    errDll_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q     <= ST_IDLE;
            byteCnt_q   <= '0;
            skpCnt_q    <= '0;
            dataOut_q   <= 8'h00;
            dataValid_q <= 1'b0;
            pktStart_q  <= 1'b0;
            pktEnd_q    <= 1'b0;
            pktType_q   <= 1'b0;
            skpOs_q     <= 1'b0;
            errDll_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            byteCnt_q   <= byteCnt_d;
            skpCnt_q    <= skpCnt_d;
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
            pktStart_q  <= pktStart_d;
            pktEnd_q    <= pktEnd_d;
            pktType_q   <= pktType_d;
            skpOs_q     <= skpOs_d;
            errDll_q    <= errDll_d;
        end
    end

    assign DATA_OUT   = dataOut_q;
    assign DATA_VALID = dataValid_q;
    assign PKT_START  = pktStart_q;
    assign PKT_END    = pktEnd_q;
    assign PKT_TYPE   = pktType_q;
    assign SKP_OS     = skpOs_q;
    assign ERROR_DLL  = errDll_q;

endmodule

// File: tb/tb_pcie_phy_rx_deframer.sv
// Directed, table-driven bench for pcie_phy_rx_deframer with hand-computed
// expected flags, plus a hand-written asynchronous mid-packet reset sequence.
module tb_pcie_phy_rx_deframer;

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;

    // Expected-flag bits in {DATA_VALID, PKT_START, PKT_END, PKT_TYPE, SKP_OS, ERROR_DLL} order
    localparam logic [5:0] F_DV = 6'b100000;
    localparam logic [5:0] F_ST = 6'b010000;
    localparam logic [5:0] F_EN = 6'b001000;
    localparam logic [5:0] F_TY = 6'b000100;
    localparam logic [5:0] F_SK = 6'b000010;
    localparam logic [5:0] F_ER = 6'b000001;
    localparam logic [5:0] F_0  = 6'b000000;

    typedef struct {
        int         tag;
        logic       valid;
        logic       k;
        logic [7:0] data;
        logic [5:0] flags;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetL;
    logic [7:0] rxData;
    logic       rxK;
    logic       rxValid;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       pktStart;
    logic       pktEnd;
    logic       pktType;
    logic       skpOs;
    logic       errorDll;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pcie_phy_rx_deframer dut (
        .CLK       (clk),
        .RESET_L   (resetL),
        .RX_DATA   (rxData),
        .RX_K      (rxK),
        .RX_VALID  (rxValid),
        .DATA_OUT  (dataOut),
        .DATA_VALID(dataValid),
        .PKT_START (pktStart),
        .PKT_END   (pktEnd),
        .PKT_TYPE  (pktType),
        .SKP_OS    (skpOs),
        .ERROR_DLL (errorDll)
    );

    task automatic addVec(input int tag, input logic valid, input logic k,
                          input logic [7:0] data, input logic [5:0] flags);
        vec_t v;
        v.tag   = tag;
        v.valid = valid;
        v.k     = k;
        v.data  = data;
        v.flags = flags;
        vecs.push_back(v);
    endtask

    task automatic addK(input int tag, input logic [7:0] sym, input logic [5:0] flags);
        addVec(tag, 1'b1, 1'b1, sym, flags);
    endtask

    task automatic addD(input int tag, input logic [7:0] data, input logic [5:0] flags);
        addVec(tag, 1'b1, 1'b0, data, flags);
    endtask

    // Drive one symbol at the falling edge and return just after the capturing edge
    task automatic applyStimulus(input logic valid, input logic k, input logic [7:0] data);
        @(negedge clk);
        rxValid = valid;
        rxK     = k;
        rxData  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] expFlags,
                               input logic [7:0] expData, input logic chkData);
        logic [5:0] act;
        act = {dataValid, pktStart, pktEnd, pktType, skpOs, errorDll};
        checks++;
        if (act !== expFlags || (chkData && dataOut !== expData)) begin
            errors++;
            $display("[TB] FAIL %s: got flags(dv,st,en,ty,sk,er)=%b data=%h, expected flags=%b data=%h",
                     name, act, dataOut, expFlags, expData);
        end
    endtask

    initial begin
        resetL  = 1'b0;
        rxValid = 1'b0;
        rxK     = 1'b0;
        rxData  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset state", F_0, 8'h00, 1'b1);
        @(negedge clk);
        resetL = 1'b1;

        // Plain TLP
        addK(1, K_STP, F_0);
        addD(1, 8'h11, F_DV | F_ST);
        addD(1, 8'h22, F_DV);
        addD(1, 8'h33, F_DV);
        addK(1, K_END, F_EN);

        // IDLE decode: logical idle ignored, stray data and K symbols flagged
        addD(2, 8'h00, F_0);
        addD(2, 8'h42, F_ER);
        addK(2, 8'hF7, F_ER);
        addK(2, K_SKP, F_ER);
        addK(2, K_END, F_ER);

        // DLLP with exact length, then one byte short
        addK(3, K_SDP, F_TY);
        for (int i = 1; i <= 6; i++) addD(3, 8'(i), F_DV | F_TY | ((i == 1) ? F_ST : F_0));
        addK(3, K_END, F_EN | F_TY);
        addK(3, K_SDP, F_TY);
        for (int i = 1; i <= 5; i++) addD(3, 8'(i), F_DV | F_TY | ((i == 1) ? F_ST : F_0));
        addK(3, K_END, F_EN | F_TY | F_ER);

        // SKP ordered sets: good, too many SKPs, bad terminator, empty, back-to-back
        addK(4, K_COM, F_TY);
        for (int i = 0; i < 3; i++) addK(4, K_SKP, F_TY);
        addD(4, 8'h00, F_SK | F_TY);
        addK(4, K_COM, F_TY);
        for (int i = 0; i < 5; i++) addK(4, K_SKP, F_TY);
        addK(4, K_SKP, F_ER | F_TY);
        addD(4, 8'h00, F_TY);
        addK(4, K_COM, F_TY);
        addK(4, K_SKP, F_TY);
        addD(4, 8'h55, F_SK | F_ER | F_TY);
        addK(4, K_COM, F_TY);
        addD(4, 8'h00, F_ER | F_TY);
        addK(4, K_COM, F_TY);
        addK(4, K_SKP, F_TY);
        addK(4, K_COM, F_SK | F_TY);
        addK(4, K_SKP, F_TY);
        addD(4, 8'h00, F_SK | F_TY);

        // Zero-payload TLP
        addK(5, K_STP, F_0);
        addK(5, K_END, F_EN | F_ER);

        // Nullified TLP, then TLP aborted by an SDP that opens a clean DLLP
        addK(6, K_STP, F_0);
        addD(6, 8'hAA, F_DV | F_ST);
        addD(6, 8'hBB, F_DV);
        addK(6, K_EDB, F_EN | F_ER);
        addK(6, K_STP, F_0);
        addD(6, 8'hAA, F_DV | F_ST);
        addK(6, K_SDP, F_EN | F_ER | F_TY);
        for (int i = 1; i <= 6; i++) addD(6, 8'(8'hC0 + i), F_DV | F_TY | ((i == 1) ? F_ST : F_0));
        addK(6, K_END, F_EN | F_TY);

        // TLP overflow: byte 33 closes the packet, tail swallowed up to END
        addK(7, K_STP, F_0);
        for (int i = 1; i <= 32; i++) addD(7, 8'(i), F_DV | ((i == 1) ? F_ST : F_0));
        addD(7, 8'h21, F_EN | F_ER);
        addD(7, 8'h77, F_0);
        addK(7, K_END, F_0);
        addD(7, 8'h00, F_0);
        addK(7, K_STP, F_0);
        addD(7, 8'h5A, F_DV | F_ST);
        addK(7, K_END, F_EN);

        // RX_VALID gaps inside a TLP, including a masked END
        addK(8, K_STP, F_0);
        addVec(8, 1'b0, 1'b1, K_END, F_0);
        addD(8, 8'h11, F_DV | F_ST);
        addVec(8, 1'b0, 1'b0, 8'h99, F_0);
        addD(8, 8'h22, F_DV);
        addD(8, 8'h33, F_DV);
        addVec(8, 1'b0, 1'b1, K_EDB, F_0);
        addK(8, K_END, F_EN);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].valid, vecs[i].k, vecs[i].data);
            checkOutput($sformatf("test%0d vec%0d", vecs[i].tag, i),
                        vecs[i].flags, vecs[i].data, vecs[i].flags[5]);
        end

        // Asynchronous reset in the middle of a TLP
        applyStimulus(1'b1, 1'b1, K_STP);
        checkOutput("mid-reset STP", F_0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h11);
        checkOutput("mid-reset first byte", F_DV | F_ST, 8'h11, 1'b1);
        #2;
        resetL  = 1'b0;
        rxValid = 1'b1;
        rxK     = 1'b0;
        rxData  = 8'h22;
        #1;
        checkOutput("async reset clears outputs", F_0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("reset held over edge", F_0, 8'h00, 1'b1);
        @(negedge clk);
        resetL = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("post-reset idle byte", F_0, 8'h00, 1'b1);
        applyStimulus(1'b1, 1'b1, K_END);
        checkOutput("post-reset END in IDLE", F_ER, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
